// File: rtl/tlp_xcvr_pkg.sv
// Shared types and TLP header packing for the tlp-xcvr transmit/receive pair.
// Header helpers build 3-DW CplD and MemWr32 headers from their fields.
package tlp_xcvr_pkg;

  typedef enum logic [1:0] {
    ACT_NOP   = 2'd0,
    ACT_READ  = 2'd1,
    ACT_WRITE = 2'd2
  } ActType;

  typedef logic [4:0]  ExtChan;
  typedef logic [15:0] BusID;
  typedef logic [7:0]  Tag;

  typedef struct packed {
    ActType      typ;
    BusID        reqID;
    Tag          tag;
    ExtChan      chan;
    logic [6:0]  lowAddr;
    logic [31:0] data;
  } Action;

  localparam logic [2:0]  FMT_3DW_DATA = 3'b010;
  localparam logic [4:0]  TYPE_CPL     = 5'b01010;
  localparam logic [4:0]  TYPE_MWR     = 5'b00000;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic [2:0] fmt;
    logic [4:0] typ;
    logic       r0;
    logic [2:0] tc;
    logic [3:0] r1;
    logic       td;
    logic       ep;
    logic [1:0] attr;
    logic [1:0] at;
    logic [9:0] length;
  } CplHdr0;

  typedef struct packed {
    BusID        cplID;
    logic [2:0]  status;
    logic        bcm;
    logic [11:0] byteCount;
  } CplHdr1;

  typedef CplHdr0 Write0;

  typedef struct packed {
    BusID       reqID;
    Tag         tag;
    logic [3:0] lastBE;
    logic [3:0] firstBE;
  } Write1;

  typedef struct packed {
    logic [31:0] dw2;
    logic [31:0] dw1;
    logic [31:0] dw0;
  } TlpHdr;

  function automatic TlpHdr genCplHdr(
    input BusID       cpl_id,
    input BusID       req_id,
    input Tag         tag,
    input logic [6:0] low_addr
  );
    CplHdr0 h0;
    CplHdr1 h1;
    TlpHdr  h;
    h0        = '0;
    h0.fmt    = FMT_3DW_DATA;
    h0.typ    = TYPE_CPL;
    h0.length = 10'd1;
    h1           = '0;
    h1.cplID     = cpl_id;
    h1.byteCount = 12'd4;
    h.dw0 = h0;
    h.dw1 = h1;
    h.dw2 = {req_id, tag, 1'b0, low_addr};
    return h;
  endfunction

  function automatic TlpHdr genMsiHdr(
    input BusID        req_id,
    input logic [31:2] addr
  );
    Write0 h0;
    Write1 h1;
    TlpHdr h;
    h0        = '0;
    h0.fmt    = FMT_3DW_DATA;
    h0.typ    = TYPE_MWR;
    h0.length = 10'd1;
    h1         = '0;
    h1.reqID   = req_id;
    h1.firstBE = 4'hF;
    h.dw0 = h0;
    h.dw1 = h1;
    h.dw2 = {addr, 2'b00};
    return h;
  endfunction

endpackage

// File: rtl/tlp_send.sv
// Transmit half of tlp-xcvr: pops actions, drives register access, emits CplD TLPs.
// Define TLP_SEND_MSI_EN to add MSI MemWr32 generation from msiReq_in edges.
module tlp_send
  import tlp_xcvr_pkg::*;
#(
  parameter int RD_TIMEOUT = 255
) (
  input  logic        pcieClk_in,
  input  logic        pcieRst_in,
  input  logic [12:0] cfgBusDev_in,
  input  Action       actData_in,
  input  logic        actValid_in,
  output logic        actReady_out,
  output ExtChan      cpuChan_out,
  output logic [31:0] cpuWrData_out,
  output logic        cpuWrValid_out,
  output logic        cpuRdReq_out,
  input  logic [31:0] cpuRdData_in,
  input  logic        cpuRdValid_in,
  output logic [63:0] txData_out,
  output logic        txValid_out,
  input  logic        txReady_in,
  output logic        txSOP_out,
  output logic        txEOP_out
`ifdef TLP_SEND_MSI_EN
  ,
  input  logic        msiReq_in,
  input  logic [31:0] msiAddr_in,
  input  logic [15:0] msiData_in
`endif
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_REG_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_CPL0,
    S_CPL1,
    S_CPL2
`ifdef TLP_SEND_MSI_EN
    ,
    S_MSI0,
    S_MSI1,
    S_MSI2
`endif
  } state_t;

  state_t      state, state_d;
  logic [TW-1:0] timer, timer_d;
  BusID        req_id, req_id_d;
  Tag          tag, tag_d;
  ExtChan      chan, chan_d;
  logic [6:0]  low_addr, low_addr_d;
  logic [31:0] data, data_d;
  BusID        cpl_id;
  TlpHdr       cpl_hdr;

  assign cpl_id  = {cfgBusDev_in, 3'b000};
  assign cpl_hdr = genCplHdr(cpl_id, req_id, tag, low_addr);

  assign cpuChan_out   = chan;
  assign cpuWrData_out = data;

`ifdef TLP_SEND_MSI_EN
  logic        msi_req_q;
  logic        msi_pend;
  logic        msi_clr;
  logic [31:2] msi_addr, msi_addr_d;
  TlpHdr       msi_hdr;

  assign msi_hdr = genMsiHdr(cpl_id, msi_addr);

  // Edges arriving while a request is pending collapse into it.
  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      msi_req_q <= 1'b0;
      msi_pend  <= 1'b0;
      msi_addr  <= '0;
    end else begin
      msi_req_q <= msiReq_in;
      msi_pend  <= (msi_pend & ~msi_clr) | (msiReq_in & ~msi_req_q);
      msi_addr  <= msi_addr_d;
    end
  end
`endif

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      state    <= S_IDLE;
      timer    <= '0;
      req_id   <= '0;
      tag      <= '0;
      chan     <= '0;
      low_addr <= '0;
      data     <= '0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      req_id   <= req_id_d;
      tag      <= tag_d;
      chan     <= chan_d;
      low_addr <= low_addr_d;
      data     <= data_d;
    end
  end

  always_comb begin
    state_d        = state;
    timer_d        = timer;
    req_id_d       = req_id;
    tag_d          = tag;
    chan_d         = chan;
    low_addr_d     = low_addr;
    data_d         = data;
    actReady_out   = 1'b0;
    cpuWrValid_out = 1'b0;
    cpuRdReq_out   = 1'b0;
    txValid_out    = 1'b0;
    txSOP_out      = 1'b0;
    txEOP_out      = 1'b0;
    txData_out     = '0;
`ifdef TLP_SEND_MSI_EN
    msi_clr    = 1'b0;
    msi_addr_d = msi_addr;
`endif
    unique case (state)
      S_IDLE: begin
        if (actValid_in) begin
          actReady_out = 1'b1;
          req_id_d     = actData_in.reqID;
          tag_d        = actData_in.tag;
          chan_d       = actData_in.chan;
          low_addr_d   = actData_in.lowAddr;
          data_d       = actData_in.data;
          if (actData_in.typ == ACT_WRITE) begin
            state_d = S_REG_WR;
          end else if (actData_in.typ == ACT_READ) begin
            state_d = S_RD_REQ;
          end
        end
`ifdef TLP_SEND_MSI_EN
        else if (msi_pend) begin
          msi_addr_d = msiAddr_in[31:2];
          data_d     = {16'h0, msiData_in};
          state_d    = S_MSI0;
        end
`endif
      end
      S_REG_WR: begin
        cpuWrValid_out = 1'b1;
        state_d        = S_IDLE;
      end
      S_RD_REQ: begin
        cpuRdReq_out = 1'b1;
        timer_d      = '0;
        state_d      = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (cpuRdValid_in) begin
          data_d  = cpuRdData_in;
          state_d = S_CPL0;
        end else if (timer == TW'(RD_TIMEOUT)) begin
          data_d  = TIMEOUT_DATA;
          state_d = S_CPL0;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      S_CPL0: begin
        txValid_out = 1'b1;
        txSOP_out   = 1'b1;
        txData_out  = {cpl_hdr.dw1, cpl_hdr.dw0};
        if (txReady_in) state_d = S_CPL1;
      end
      // Odd-DW address: payload packs beside DW2 in the same QW.
      S_CPL1: begin
        txValid_out = 1'b1;
        if (low_addr[2]) begin
          txEOP_out  = 1'b1;
          txData_out = {data, cpl_hdr.dw2};
          if (txReady_in) state_d = S_IDLE;
        end else begin
          txData_out = {32'h0, cpl_hdr.dw2};
          if (txReady_in) state_d = S_CPL2;
        end
      end
      S_CPL2: begin
        txValid_out = 1'b1;
        txEOP_out   = 1'b1;
        txData_out  = {32'h0, data};
        if (txReady_in) state_d = S_IDLE;
      end
`ifdef TLP_SEND_MSI_EN
      S_MSI0: begin
        txValid_out = 1'b1;
        txSOP_out   = 1'b1;
        txData_out  = {msi_hdr.dw1, msi_hdr.dw0};
        if (txReady_in) state_d = S_MSI1;
      end
      S_MSI1: begin
        txValid_out = 1'b1;
        if (msi_addr[2]) begin
          txEOP_out  = 1'b1;
          txData_out = {data, msi_hdr.dw2};
          if (txReady_in) begin
            msi_clr = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          txData_out = {32'h0, msi_hdr.dw2};
          if (txReady_in) state_d = S_MSI2;
        end
      end
      S_MSI2: begin
        txValid_out = 1'b1;
        txEOP_out   = 1'b1;
        txData_out  = {32'h0, data};
        if (txReady_in) begin
          msi_clr = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlp_send.sv
// Self-checking bench for tlp_send: beat-level model plus literal pins.
// Default build (TLP_SEND_MSI_EN undefined).
module tb_tlp_send;
  import tlp_xcvr_pkg::*;

  localparam int RD_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] cfg;
  Action       act_data;
  logic        act_valid;
  logic        act_ready;
  ExtChan      chan;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        rd_req;
  logic [31:0] rd_data_in;
  logic        rd_valid_in;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;

  always #4 clk = ~clk;

  tlp_send #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
    .pcieClk_in    (clk),
    .pcieRst_in    (rst),
    .cfgBusDev_in  (cfg),
    .actData_in    (act_data),
    .actValid_in   (act_valid),
    .actReady_out  (act_ready),
    .cpuChan_out   (chan),
    .cpuWrData_out (wr_data),
    .cpuWrValid_out(wr_valid),
    .cpuRdReq_out  (rd_req),
    .cpuRdData_in  (rd_data_in),
    .cpuRdValid_in (rd_valid_in),
    .txData_out    (tx_data),
    .txValid_out   (tx_valid),
    .txReady_in    (tx_ready),
    .txSOP_out     (tx_sop),
    .txEOP_out     (tx_eop)
  );

  typedef struct {
    logic [63:0] d;
    bit          sop;
    bit          eop;
  } beat_t;

  typedef struct {
    ExtChan      c;
    logic [31:0] d;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  Action       aq[$];
  beat_t       exp_beats[$];
  wr_t         exp_wr[$];
  logic [63:0] cap[$];
  int          pend_rd = 0;
  bit          rd_en = 1'b1;
  logic [31:0] rd_val = 32'hCAFEF00D;
  int          rd_delay = 4;
  int          beats_seen = 0;
  int          wr_seen = 0;
  ExtChan      last_chan;
  logic [31:0] last_wr;
  int          cyc = 0;
  int          rdreq_cyc = 0;
  int          sop_cyc = 0;
  bit          pop_flag = 1'b0;
  bit          prev_stall = 1'b0;
  bit          prev_rst = 1'b1;
  bit          after_eop = 1'b0;
  logic [63:0] prev_d;
  logic [1:0]  prev_se;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic Action mk(input ActType t, input ExtChan c,
                               input logic [15:0] r, input Tag g,
                               input logic [6:0] la, input logic [31:0] d);
    Action a;
    a.typ     = t;
    a.reqID   = r;
    a.tag     = g;
    a.chan    = c;
    a.lowAddr = la;
    a.data    = d;
    return a;
  endfunction

  // Expected CplD beats built straight from the header field layout.
  function automatic void model_read(input Action a);
    logic [15:0] cid;
    logic [31:0] dw0, dw1, dw2, pay;
    cid = {cfg, 3'b000};
    dw0 = {3'b010, 5'b01010, 14'h0, 10'd1};
    dw1 = {cid, 3'b000, 1'b0, 12'd4};
    dw2 = {a.reqID, a.tag, 1'b0, a.lowAddr};
    pay = rd_en ? rd_val : 32'hDEADBEEF;
    exp_beats.push_back('{{dw1, dw0}, 1'b1, 1'b0});
    if (a.lowAddr[2]) begin
      exp_beats.push_back('{{pay, dw2}, 1'b0, 1'b1});
    end else begin
      exp_beats.push_back('{{32'h0, dw2}, 1'b0, 1'b0});
      exp_beats.push_back('{{32'h0, pay}, 1'b0, 1'b1});
    end
  endfunction

  // Monitor and compare, sampled on the falling edge.
  always @(negedge clk) begin
    beat_t b;
    wr_t   w;
    pop_flag = 1'b0;
    if (!rst) begin
      if (act_ready) begin
        chk("pop_without_valid", act_valid, 1);
        pop_flag = 1'b1;
        case (act_data.typ)
          ACT_WRITE: exp_wr.push_back('{act_data.chan, act_data.data});
          ACT_READ: begin
            pend_rd++;
            model_read(act_data);
          end
          default: ;
        endcase
      end
      if (wr_valid) begin
        wr_seen++;
        last_chan = chan;
        last_wr   = wr_data;
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_chan", chan, w.c);
          chk("wr_data", wr_data, w.d);
        end
      end
      if (rd_req) begin
        rdreq_cyc = cyc;
        chk("rdreq_expected", pend_rd > 0, 1);
        if (pend_rd > 0) pend_rd--;
      end
      if (prev_stall && !prev_rst) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, prev_d);
        chk("stall_sop_eop", {tx_sop, tx_eop}, prev_se);
      end
      if (after_eop) chk("idle_after_eop", tx_valid, 0);
      after_eop = 1'b0;
      if (tx_valid && tx_ready) begin
        beats_seen++;
        cap.push_back(tx_data);
        if (tx_sop) sop_cyc = cyc;
        if (exp_beats.size() == 0) begin
          chk("unexpected_beat", tx_data, 0);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_data", tx_data, b.d);
          chk("beat_sop", tx_sop, b.sop);
          chk("beat_eop", tx_eop, b.eop);
        end
        if (tx_eop) after_eop = 1'b1;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_d     = tx_data;
      prev_se    = {tx_sop, tx_eop};
    end
    prev_rst = rst;
  end

  // Action FIFO head driver.
  initial begin
    act_valid = 1'b0;
    act_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pop_flag && aq.size() > 0) void'(aq.pop_front());
      act_valid = aq.size() > 0;
      act_data  = act_valid ? aq[0] : '0;
    end
  end

  // Register-bank read responder.
  initial begin
    rd_valid_in = 1'b0;
    rd_data_in  = '0;
    forever begin
      @(negedge clk);
      if (rd_req && rd_en && !rst) begin
        repeat (rd_delay) @(posedge clk);
        #1;
        rd_valid_in = 1'b1;
        rd_data_in  = rd_val;
        @(posedge clk);
        #1;
        rd_valid_in = 1'b0;
        rd_data_in  = '0;
      end
    end
  end

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while ((aq.size() > 0 || exp_beats.size() > 0 || exp_wr.size() > 0 ||
            pend_rd > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(name, n < budget, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_sop(input int b0, input int budget);
    int n = 0;
    while (beats_seen < b0 + 1 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("sop_wait", n < budget, 1);
    #1;
  endtask

  int b0, w0;

  initial begin
    rst      = 1'b1;
    cfg      = {8'h12, 5'h03};
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_sop", tx_sop, 0);
    chk("rst_tx_eop", tx_eop, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_act_ready", act_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Register write: one strobe, no TX traffic.
    b0 = beats_seen;
    w0 = wr_seen;
    aq.push_back(mk(ACT_WRITE, 5'd3, 16'h0, 8'h0, 7'h0, 32'h12345678));
    wait_done(50, "write_done");
    chk("write_count", wr_seen - w0, 1);
    chk("write_chan_lit", last_chan, 3);
    chk("write_data_lit", last_wr, 32'h12345678);
    chk("write_no_tx", beats_seen - b0, 0);

    // Even-DW read: three beats.
    cap.delete();
    aq.push_back(mk(ACT_READ, 5'd1, 16'h0100, 8'h05, 7'h08, 32'h0));
    wait_done(100, "read_even_done");
    chk("read_even_beats", cap.size(), 3);
    chk("read_even_b0_lit", cap[0], 64'h1218_0004_4A00_0001);
    chk("read_even_b1_lit", cap[1][31:0], 32'h01000508);
    chk("read_even_b2_lit", cap[2], 64'h0000_0000_CAFE_F00D);

    // Odd-DW read: two beats.
    cap.delete();
    aq.push_back(mk(ACT_READ, 5'd1, 16'h0100, 8'h05, 7'h0C, 32'h0));
    wait_done(100, "read_odd_done");
    chk("read_odd_beats", cap.size(), 2);
    chk("read_odd_b1_lit", cap[1], 64'hCAFE_F00D_0100_050C);

    // Backpressure for five cycles on the second beat.
    cap.delete();
    b0 = beats_seen;
    aq.push_back(mk(ACT_READ, 5'd2, 16'h0200, 8'h11, 7'h10, 32'h0));
    wait_sop(b0, 100);
    tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_done(100, "stall_done");
    chk("stall_beats", cap.size(), 3);
    chk("stall_b1_lit", cap[1], 64'h0000_0000_0200_1110);

    // Read timeout completes with the poison pattern.
    cap.delete();
    rd_en = 1'b0;
    aq.push_back(mk(ACT_READ, 5'd4, 16'h0300, 8'h22, 7'h10, 32'h0));
    wait_done(400, "timeout_done");
    rd_en = 1'b1;
    chk("timeout_latency", sop_cyc - rdreq_cyc, RD_TIMEOUT + 2);
    chk("timeout_b2_lit", cap[2], 64'h0000_0000_DEAD_BEEF);

    // Queued mix: reads back-to-back with a write and a dropped NOP.
    cap.delete();
    w0 = wr_seen;
    rd_val = 32'h0BAD_F00D;
    aq.push_back(mk(ACT_READ, 5'd1, 16'h0400, 8'h07, 7'h0C, 32'h0));
    aq.push_back(mk(ACT_NOP, 5'd9, 16'h0, 8'h0, 7'h0, 32'hFFFF_FFFF));
    aq.push_back(mk(ACT_READ, 5'd1, 16'h0400, 8'h08, 7'h08, 32'h0));
    aq.push_back(mk(ACT_WRITE, 5'd5, 16'h0, 8'h0, 7'h0, 32'hA5A5_5A5A));
    wait_done(200, "mix_done");
    chk("mix_beats", cap.size(), 5);
    chk("mix_writes", wr_seen - w0, 1);
    chk("mix_wr_data_lit", last_wr, 32'hA5A5_5A5A);

    // Reset while the second beat is stalled abandons the packet.
    cap.delete();
    b0 = beats_seen;
    aq.push_back(mk(ACT_READ, 5'd1, 16'h0500, 8'h09, 7'h0C, 32'h0));
    wait_sop(b0, 100);
    tx_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_beats.delete();
    pend_rd = 0;
    @(negedge clk);
    chk("rst_mid_valid", tx_valid, 0);
    chk("rst_mid_sop", tx_sop, 0);
    @(posedge clk);
    #1 tx_ready = 1'b1;

    // Recovery after reset.
    cap.delete();
    aq.push_back(mk(ACT_READ, 5'd1, 16'h0600, 8'h0A, 7'h08, 32'h0));
    wait_done(100, "recover_done");
    chk("recover_beats", cap.size(), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
